// File: rtl/data_bus_gen.sv
// Multi-lane link transmitter/receiver: a TX FSM that drives ordered sets or FIFO data
// onto the lanes, and an RX side that decodes ordered-set ids and queues received bytes.
module data_bus_gen #(
   parameter int LANES    = 2,
   parameter int DW       = 8,
   parameter int OS_LEN   = 4,
   parameter int TX_DEPTH = 8,
   parameter int RX_DEPTH = 8
) (
   input  logic                  fsm_clk,
   input  logic                  rst,
   input  logic [3:0]            d_sel,
   input  logic                  bonded,
   input  logic [DW-1:0]         tl_data_in,
   input  logic                  tl_valid_in,
   output logic                  tl_ready_out,
   output logic [LANES*DW-1:0]   lane_tx,
   output logic                  tx_lanes_on,
   output logic                  os_sent,
   input  logic                  data_os,
   input  logic                  rx_lanes_on,
   input  logic [LANES*DW-1:0]   lane_rx,
   output logic [LANES*4-1:0]    os_in,
   output logic [DW-1:0]         tl_data_out,
   output logic                  tl_valid_out,
   input  logic                  tl_ready_in,
   output logic                  rx_overflow
);

   localparam int TPW = $clog2(TX_DEPTH);
   localparam int TCW = $clog2(TX_DEPTH + 1);
   localparam int RPW = $clog2(RX_DEPTH);
   localparam int RCW = $clog2(RX_DEPTH + 1);
   localparam int OCW = (OS_LEN > 1) ? $clog2(OS_LEN) : 1;

   typedef enum logic [1:0] {S_IDLE, S_OS_SEND, S_OS_DONE, S_DATA} state_t;

   state_t                r_state;
   logic [OCW-1:0]        r_os_cnt;
   logic [3:0]            r_os_id;
   logic [LANES*DW-1:0]   r_lane_tx;
   logic                  r_tx_on;
   logic                  r_os_sent;

   logic [LANES-1:0]      w_lane_en;
   logic [TCW-1:0]        w_tx_act;
   logic [RCW-1:0]        w_rx_act;
   logic [LANES*DW-1:0]   w_os_word;
   logic [LANES*DW-1:0]   w_data_word;

   assign w_lane_en = bonded ? {LANES{1'b1}} : LANES'(1);
   assign w_tx_act  = bonded ? TCW'(LANES) : TCW'(1);
   assign w_rx_act  = bonded ? RCW'(LANES) : RCW'(1);

   logic [DW-1:0]         r_tx_mem [TX_DEPTH];
   logic [TPW-1:0]        r_tx_wr;
   logic [TPW-1:0]        r_tx_rd;
   logic [TCW-1:0]        r_tx_cnt;
   logic                  w_tx_push;
   logic                  w_tx_pop;
   logic [DW-1:0]         w_tx_byte [LANES];

   assign tl_ready_out = (r_tx_cnt < TCW'(TX_DEPTH));
   assign w_tx_push    = tl_valid_in & tl_ready_out;
   assign w_tx_pop     = (r_state == S_DATA) && (d_sel == 4'd8) && (r_tx_cnt >= w_tx_act);

   // Oldest byte goes to lane 0; inactive lanes are forced to zero.
   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_tx_byte[gi]             = r_tx_mem[r_tx_rd + TPW'(gi)];
      assign w_os_word[gi*DW +: DW]    = w_lane_en[gi] ? DW'({4'hF, d_sel}) : '0;
      assign w_data_word[gi*DW +: DW]  = w_lane_en[gi] ? w_tx_byte[gi] : '0;
   end

   always_ff @(posedge fsm_clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wr] <= tl_data_in;
   end

   always_ff @(posedge fsm_clk or negedge rst) begin
      if (!rst) begin
         r_tx_wr  <= '0;
         r_tx_rd  <= '0;
         r_tx_cnt <= '0;
      end else begin
         if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
         if (w_tx_pop)  r_tx_rd <= r_tx_rd + TPW'(w_tx_act);
         r_tx_cnt <= r_tx_cnt + TCW'(w_tx_push) - (w_tx_pop ? w_tx_act : '0);
      end
   end

   // While an OS is in flight d_sel equals the latched id, so w_os_word serves both entry and hold.
   always_ff @(posedge fsm_clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_os_cnt  <= '0;
         r_os_id   <= '0;
         r_lane_tx <= '0;
         r_tx_on   <= 1'b0;
         r_os_sent <= 1'b0;
      end else begin
         r_os_sent <= 1'b0;
         r_lane_tx <= '0;
         r_tx_on   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (d_sel inside {[4'd1:4'd7]}) begin
                  r_state   <= S_OS_SEND;
                  r_os_cnt  <= '0;
                  r_os_id   <= d_sel;
                  r_lane_tx <= w_os_word;
                  r_tx_on   <= 1'b1;
               end else if (d_sel == 4'd8) begin
                  r_state <= S_DATA;
                  r_tx_on <= 1'b1;
               end
            end
            S_OS_SEND: begin
               if (d_sel != r_os_id) begin
                  r_state <= S_IDLE;
               end else if (r_os_cnt == OCW'(OS_LEN - 1)) begin
                  r_state   <= S_OS_DONE;
                  r_os_sent <= 1'b1;
               end else begin
                  r_os_cnt  <= r_os_cnt + 1'b1;
                  r_lane_tx <= w_os_word;
                  r_tx_on   <= 1'b1;
               end
            end
            S_OS_DONE: begin
               if (d_sel != r_os_id) r_state <= S_IDLE;
            end
            S_DATA: begin
               if (d_sel != 4'd8) begin
                  r_state <= S_IDLE;
               end else begin
                  r_tx_on <= 1'b1;
                  if (w_tx_pop) r_lane_tx <= w_data_word;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign lane_tx     = r_lane_tx;
   assign tx_lanes_on = r_tx_on;
   assign os_sent     = r_os_sent;

   logic [DW-1:0]         r_rx_mem [RX_DEPTH];
   logic [RPW-1:0]        r_rx_wr;
   logic [RPW-1:0]        r_rx_rd;
   logic [RCW-1:0]        r_rx_cnt;
   logic                  r_rx_ovf;
   logic                  w_rx_grp;
   logic                  w_rx_fit;
   logic                  w_rx_push;
   logic                  w_rx_pop;

   assign w_rx_grp     = rx_lanes_on & data_os;
   assign w_rx_fit     = (RCW'(RX_DEPTH) - r_rx_cnt) >= w_rx_act;
   assign w_rx_push    = w_rx_grp & w_rx_fit;
   assign tl_valid_out = (r_rx_cnt != '0);
   assign tl_data_out  = r_rx_mem[r_rx_rd];
   assign w_rx_pop     = tl_valid_out & tl_ready_in;

   always_ff @(posedge fsm_clk) begin
      if (w_rx_push) begin
         for (int i = 0; i < LANES; i++) begin
            if (w_lane_en[i]) r_rx_mem[r_rx_wr + RPW'(i)] <= lane_rx[i*DW +: DW];
         end
      end
   end

   // A group that does not fit is dropped whole so lane order is never split.
   always_ff @(posedge fsm_clk or negedge rst) begin
      if (!rst) begin
         r_rx_wr  <= '0;
         r_rx_rd  <= '0;
         r_rx_cnt <= '0;
         r_rx_ovf <= 1'b0;
      end else begin
         if (w_rx_push) r_rx_wr <= r_rx_wr + RPW'(w_rx_act);
         if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
         r_rx_cnt <= r_rx_cnt + (w_rx_push ? w_rx_act : '0) - RCW'(w_rx_pop);
         if (w_rx_grp && !w_rx_fit) r_rx_ovf <= 1'b1;
      end
   end

   assign rx_overflow = r_rx_ovf;

   for (genvar gi = 0; gi < LANES; gi++) begin : g_os_in
      logic [3:0] r_os_lane;
      always_ff @(posedge fsm_clk or negedge rst) begin
         if (!rst) begin
            r_os_lane <= '0;
         end else if (rx_lanes_on && !data_os && w_lane_en[gi] &&
                      (lane_rx[gi*DW+DW-4 +: 4] == 4'hF)) begin
            r_os_lane <= lane_rx[gi*DW +: 4];
         end
      end
      assign os_in[gi*4 +: 4] = r_os_lane;
   end

endmodule

// File: tb/tb_data_bus_gen.sv
// Self-checking bench for data_bus_gen: direct checks for the OS path and reset,
// queue-based scoreboards for the TX lane data and the RX byte stream.
module tb_data_bus_gen;
   localparam int LANES = 2;
   localparam int RX_DEPTH = 8;

   logic                fsm_clk = 1'b0;
   logic                rst = 1'b0;
   logic [3:0]          d_sel = '0;
   logic                bonded = 1'b1;
   logic [7:0]          tl_data_in = '0;
   logic                tl_valid_in = 1'b0;
   logic                tl_ready_out;
   logic [LANES*8-1:0]  lane_tx;
   logic                tx_lanes_on;
   logic                os_sent;
   logic                data_os = 1'b0;
   logic                rx_lanes_on = 1'b0;
   logic [LANES*8-1:0]  lane_rx = '0;
   logic [LANES*4-1:0]  os_in;
   logic [7:0]          tl_data_out;
   logic                tl_valid_out;
   logic                tl_ready_in = 1'b0;
   logic                rx_overflow;

   data_bus_gen #(.LANES(LANES), .DW(8), .OS_LEN(4), .TX_DEPTH(8), .RX_DEPTH(RX_DEPTH)) dut (
      .fsm_clk(fsm_clk), .rst(rst), .d_sel(d_sel), .bonded(bonded),
      .tl_data_in(tl_data_in), .tl_valid_in(tl_valid_in), .tl_ready_out(tl_ready_out),
      .lane_tx(lane_tx), .tx_lanes_on(tx_lanes_on), .os_sent(os_sent),
      .data_os(data_os), .rx_lanes_on(rx_lanes_on), .lane_rx(lane_rx), .os_in(os_in),
      .tl_data_out(tl_data_out), .tl_valid_out(tl_valid_out), .tl_ready_in(tl_ready_in),
      .rx_overflow(rx_overflow)
   );

   always #5 fsm_clk = ~fsm_clk;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] tx_stim[$];
   logic [7:0] tx_q[$];
   logic [7:0] rx_q[$];
   logic       ovf_m = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge fsm_clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_lane_tx"}, lane_tx, 0);
      check({tag, "_tx_on"}, tx_lanes_on, 0);
      check({tag, "_os_sent"}, os_sent, 0);
      check({tag, "_os_in"}, os_in, 0);
      check({tag, "_valid_out"}, tl_valid_out, 0);
      check({tag, "_ready_out"}, tl_ready_out, 1);
      check({tag, "_rx_ovf"}, rx_overflow, 0);
   endtask

   // Drives tx_stim into the TX FIFO and checks every non-zero lane group against tx_q.
   task automatic tx_run(input int max_cyc, input int flip_at);
      for (int c = 0; c < max_cyc && (tx_stim.size() > 0 || tx_q.size() > 0); c++) begin
         logic acc;
         logic b;
         if (c == flip_at) bonded = ~bonded;
         b = bonded;
         tl_valid_in = (tx_stim.size() > 0);
         if (tl_valid_in) tl_data_in = tx_stim[0];
         acc = tl_valid_in && tl_ready_out;
         step();
         if (acc) tx_q.push_back(tx_stim.pop_front());
         check("tx_lanes_on", tx_lanes_on, 1);
         if (lane_tx != '0) begin
            $display("tx group bonded=%0d lane_tx=%h", b, lane_tx);
            for (int i = 0; i < LANES; i++) begin
               if (b || i == 0) begin
                  if (tx_q.size() == 0) check("tx_extra_byte", 0, 1);
                  else check("tx_lane_byte", lane_tx[i*8 +: 8], tx_q.pop_front());
               end else begin
                  check("tx_idle_lane", lane_tx[i*8 +: 8], 0);
               end
            end
         end
      end
      tl_valid_in = 1'b0;
      check("tx_drained", tx_q.size() + tx_stim.size(), 0);
   endtask

   // One RX cycle against the queue model; inputs are set by the caller.
   task automatic rx_cycle();
      logic pop;
      int   act;
      check("rx_valid", tl_valid_out, rx_q.size() != 0);
      if (rx_q.size() != 0) check("rx_data", tl_data_out, rx_q[0]);
      pop = (rx_q.size() != 0) && tl_ready_in;
      act = bonded ? LANES : 1;
      if (rx_lanes_on && data_os) begin
         if (RX_DEPTH - rx_q.size() >= act) begin
            for (int i = 0; i < act; i++) rx_q.push_back(lane_rx[i*8 +: 8]);
         end else begin
            ovf_m = 1'b1;
         end
      end
      step();
      if (pop) begin
         $display("rx byte %h", rx_q[0]);
         void'(rx_q.pop_front());
      end
      check("rx_overflow", rx_overflow, ovf_m);
   endtask

   initial begin
      #2;
      check_reset_values("por");
      step();
      step();
      rst = 1'b1;
      step();

      // Ordered set held to completion, then OS_DONE hold.
      bonded = 1'b1;
      d_sel = 4'd3;
      for (int k = 0; k < 4; k++) begin
         step();
         check("os_lanes", lane_tx, 16'hF3F3);
         check("os_tx_on", tx_lanes_on, 1);
         check("os_no_pulse", os_sent, 0);
      end
      step();
      check("os_sent_pulse", os_sent, 1);
      check("os_done_lanes", lane_tx, 0);
      check("os_done_tx_on", tx_lanes_on, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         check("os_done_hold", {os_sent, tx_lanes_on}, 0);
      end
      d_sel = 4'd0;
      step();
      d_sel = 4'd3;
      step();
      check("os_restart", lane_tx, 16'hF3F3);

      // Abort after two cycles: no pulse, back to idle.
      d_sel = 4'd0;
      step();
      check("abort_lanes", lane_tx, 0);
      d_sel = 4'd3;
      step();
      step();
      d_sel = 4'd0;
      for (int k = 0; k < 6; k++) begin
         step();
         check("abort_no_pulse", {os_sent, tx_lanes_on}, 0);
      end

      // Unbonded OS and reserved select values.
      bonded = 1'b0;
      d_sel = 4'd5;
      step();
      check("os_unbonded", lane_tx, 16'h00F5);
      d_sel = 4'd0;
      step();
      d_sel = 4'd9;
      step();
      check("dsel9_idle", {tx_lanes_on, lane_tx}, 0);
      d_sel = 4'd0;
      step();

      // Data mode, bonded then single lane, then a bonded change mid-stream.
      bonded = 1'b1;
      d_sel = 4'd8;
      step();
      tx_stim = '{8'h11, 8'h22, 8'h33, 8'h44};
      tx_run(15, -1);
      bonded = 1'b0;
      tx_stim = '{8'h11, 8'h22, 8'h33, 8'h44};
      tx_run(15, -1);
      bonded = 1'b1;
      tx_stim = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67};
      tx_run(20, 4);
      d_sel = 4'd0;
      step();
      check("data_exit", tx_lanes_on, 0);

      // TX FIFO fill in idle: ready drops after the eighth accept.
      for (int k = 0; k < 8; k++) begin
         tl_valid_in = 1'b1;
         tl_data_in = 8'h80 + 8'(k);
         check("txf_ready", tl_ready_out, 1);
         step();
         tx_q.push_back(8'h80 + 8'(k));
      end
      check("txf_full", tl_ready_out, 0);
      tl_data_in = 8'h88;
      for (int k = 0; k < 2; k++) begin
         step();
         check("txf_held", {tl_ready_out, tx_lanes_on}, 0);
      end
      tx_stim.push_back(8'h88);
      bonded = 1'b0;
      d_sel = 4'd8;
      tx_run(30, -1);
      d_sel = 4'd0;
      step();

      // RX: five bonded groups with no consumer, fifth dropped.
      bonded = 1'b1;
      data_os = 1'b1;
      rx_lanes_on = 1'b1;
      lane_rx = 16'hBBAA;
      tl_ready_in = 1'b0;
      repeat (5) rx_cycle();
      check("rx_ovf_set", rx_overflow, 1);
      check("rx_stored", rx_q.size(), 8);
      rx_lanes_on = 1'b0;
      tl_ready_in = 1'b1;
      repeat (10) rx_cycle();
      check("rx_empty", tl_valid_out, 0);

      // RX: random traffic with concurrent push/pop and bonded changes.
      for (int k = 0; k < 40; k++) begin
         bonded = 1'($urandom_range(0, 1));
         rx_lanes_on = 1'($urandom_range(0, 1));
         tl_ready_in = 1'($urandom_range(0, 1));
         lane_rx = 16'($urandom);
         rx_cycle();
      end
      rx_lanes_on = 1'b0;
      tl_ready_in = 1'b1;
      for (int k = 0; k < 12 && rx_q.size() > 0; k++) rx_cycle();
      check("rx_drained", rx_q.size(), 0);

      // RX ordered-set decode.
      data_os = 1'b0;
      rx_lanes_on = 1'b1;
      bonded = 1'b1;
      lane_rx = 16'hF5F2;
      step();
      check("os_in_bonded", os_in, 8'h52);
      bonded = 1'b0;
      lane_rx = 16'hF7F9;
      step();
      check("os_in_lane0", os_in, 8'h59);
      bonded = 1'b1;
      lane_rx = 16'h3412;
      step();
      check("os_in_no_f", os_in, 8'h59);
      rx_lanes_on = 1'b0;
      lane_rx = 16'hF1F1;
      step();
      check("os_in_off", os_in, 8'h59);

      // Asynchronous reset mid-data with both FIFOs holding bytes.
      d_sel = 4'd0;
      for (int k = 0; k < 3; k++) begin
         tl_valid_in = 1'b1;
         tl_data_in = 8'hA1 + 8'(k);
         step();
      end
      tl_valid_in = 1'b0;
      data_os = 1'b1;
      rx_lanes_on = 1'b1;
      lane_rx = 16'h5A5A;
      tl_ready_in = 1'b0;
      step();
      rx_lanes_on = 1'b0;
      d_sel = 4'd8;
      step();
      check("pre_rst_tx_on", tx_lanes_on, 1);
      #2;
      rst = 1'b0;
      #1;
      check_reset_values("async_rst");
      step();
      rst = 1'b1;
      rx_q.delete();
      ovf_m = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         check("post_rst_lanes", lane_tx, 0);
         check("post_rst_rx_empty", tl_valid_out, 0);
      end

      // Reset mid-OS: aborts with no pulse.
      d_sel = 4'd0;
      step();
      d_sel = 4'd4;
      step();
      step();
      rst = 1'b0;
      #1;
      check("os_rst_tx_on", tx_lanes_on, 0);
      d_sel = 4'd0;
      step();
      rst = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check("os_rst_no_pulse", os_sent, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
